// File: rtl/vga_time_gen_if.sv
// Video timing bundle: the pixel coordinates that go to the draw stage, plus the
// sync and enable outputs that are aligned to the draw stage's output.
interface vga_time_gen_if #(
  parameter int PIX_WIDTH = 12
);
  logic [PIX_WIDTH-1:0] pix_x_o;
  logic [PIX_WIDTH-1:0] pix_y_o;
  logic                 pix_de_o;
  logic                 vga_hs_o;
  logic                 vga_vs_o;
  logic                 vga_de_o;
  logic                 frame_start_o;

  modport master (
    output pix_x_o, pix_y_o, pix_de_o, vga_hs_o, vga_vs_o, vga_de_o, frame_start_o
  );

  modport slave (
    input pix_x_o, pix_y_o, pix_de_o, vga_hs_o, vga_vs_o, vga_de_o, frame_start_o
  );
endinterface

// File: rtl/vga_time_gen.sv
// VGA raster timing generator. It drives the pixel counters to the draw stage and
// delays the sync/enable decode so that it lines up with the draw pipeline output.
module vga_time_gen #(
  parameter int PIX_WIDTH    = 12,
  parameter int H_ACTIVE     = 1280,
  parameter int H_FP         = 48,
  parameter int H_SYNC       = 112,
  parameter int H_BP         = 248,
  parameter int V_ACTIVE     = 1024,
  parameter int V_FP         = 1,
  parameter int V_SYNC       = 3,
  parameter int V_BP         = 38,
  parameter bit H_SYNC_POL   = 1'b1,
  parameter bit V_SYNC_POL   = 1'b1,
  parameter int DRAW_LATENCY = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  vga_time_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (longint'(H_TOTAL - 1) >= (longint'(1) << PIX_WIDTH)) begin : g_h_width_chk
    $error("vga_time_gen: H_TOTAL-1 does not fit in PIX_WIDTH bits");
  end
  if (longint'(V_TOTAL - 1) >= (longint'(1) << PIX_WIDTH)) begin : g_v_width_chk
    $error("vga_time_gen: V_TOTAL-1 does not fit in PIX_WIDTH bits");
  end
  if (DRAW_LATENCY < 1 || DRAW_LATENCY > 8) begin : g_lat_chk
    $error("vga_time_gen: DRAW_LATENCY must be in 1..8");
  end

  localparam logic [PIX_WIDTH-1:0] H_MAX  = PIX_WIDTH'(H_TOTAL - 1);
  localparam logic [PIX_WIDTH-1:0] V_MAX  = PIX_WIDTH'(V_TOTAL - 1);
  localparam logic [PIX_WIDTH-1:0] H_ACT  = PIX_WIDTH'(H_ACTIVE);
  localparam logic [PIX_WIDTH-1:0] V_ACT  = PIX_WIDTH'(V_ACTIVE);
  localparam logic [PIX_WIDTH-1:0] HS_BEG = PIX_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [PIX_WIDTH-1:0] HS_END = PIX_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [PIX_WIDTH-1:0] VS_BEG = PIX_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [PIX_WIDTH-1:0] VS_END = PIX_WIDTH'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [PIX_WIDTH-1:0] ONE    = {{(PIX_WIDTH-1){1'b0}}, 1'b1};

  // Sync level for a counter value; the upper bound is exclusive.
  function automatic logic sync_lvl(input logic [PIX_WIDTH-1:0] cnt,
                                    input logic [PIX_WIDTH-1:0] lo,
                                    input logic [PIX_WIDTH-1:0] hi,
                                    input logic                 pol);
    return (cnt >= lo && cnt < hi) ? pol : ~pol;
  endfunction

  logic [PIX_WIDTH-1:0] pix_x_p0, pix_y_p0;
  logic [PIX_WIDTH-1:0] x_nxt, y_nxt;
  logic                 h_last, v_last;
  logic                 de_p0, fs_p0;
  logic                 hs_raw, vs_raw, de_raw;
  logic                 hs_p [DRAW_LATENCY];
  logic                 vs_p [DRAW_LATENCY];
  logic                 de_p [DRAW_LATENCY];

  always_comb begin
    h_last = (pix_x_p0 == H_MAX);
    v_last = (pix_y_p0 == V_MAX);
    x_nxt  = h_last ? '0 : pix_x_p0 + ONE;
    y_nxt  = pix_y_p0;
    if (h_last) y_nxt = v_last ? '0 : pix_y_p0 + ONE;
    hs_raw = sync_lvl(pix_x_p0, HS_BEG, HS_END, H_SYNC_POL);
    vs_raw = sync_lvl(pix_y_p0, VS_BEG, VS_END, V_SYNC_POL);
    de_raw = (pix_x_p0 < H_ACT) && (pix_y_p0 < V_ACT);
  end

  // p0: counters plus the undelayed flags, computed from the next count so they
  // are registered yet coincide with the coordinates they describe.
  // p[0..DRAW_LATENCY-1]: sync/enable delay line matching the draw pipeline.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pix_x_p0 <= H_MAX;
      pix_y_p0 <= V_MAX;
      de_p0    <= 1'b0;
      fs_p0    <= 1'b0;
      for (int i = 0; i < DRAW_LATENCY; i++) begin
        hs_p[i] <= ~H_SYNC_POL;
        vs_p[i] <= ~V_SYNC_POL;
        de_p[i] <= 1'b0;
      end
    end else begin
      pix_x_p0 <= x_nxt;
      pix_y_p0 <= y_nxt;
      de_p0    <= (x_nxt < H_ACT) && (y_nxt < V_ACT);
      fs_p0    <= (x_nxt == '0) && (y_nxt == '0);
      hs_p[0]  <= hs_raw;
      vs_p[0]  <= vs_raw;
      de_p[0]  <= de_raw;
      for (int i = 1; i < DRAW_LATENCY; i++) begin
        hs_p[i] <= hs_p[i-1];
        vs_p[i] <= vs_p[i-1];
        de_p[i] <= de_p[i-1];
      end
    end
  end

  assign vga.pix_x_o       = pix_x_p0;
  assign vga.pix_y_o       = pix_y_p0;
  assign vga.pix_de_o      = de_p0;
  assign vga.frame_start_o = fs_p0;
  assign vga.vga_hs_o      = hs_p[DRAW_LATENCY-1];
  assign vga.vga_vs_o      = vs_p[DRAW_LATENCY-1];
  assign vga.vga_de_o      = de_p[DRAW_LATENCY-1];

endmodule

// File: tb/tb_vga_time_gen.sv
// Bench for vga_time_gen: a small-raster instance and a tiny inverted-hsync
// instance, each tracked by a counter model and a delay-line scoreboard.
module tb_vga_time_gen;

  localparam int PW = 12;
  // Instance A: small raster, latency 3, active-high syncs
  localparam int HA_A = 8, HFP_A = 2, HS_A = 3, HBP_A = 3;
  localparam int VA_A = 6, VFP_A = 1, VS_A = 2, VBP_A = 2;
  localparam int LAT_A = 3;
  localparam bit HPOL_A = 1'b1, VPOL_A = 1'b1;
  localparam int HT_A = HA_A + HFP_A + HS_A + HBP_A;
  localparam int VT_A = VA_A + VFP_A + VS_A + VBP_A;
  localparam int FR_A = HT_A * VT_A;
  // Instance B: tiny raster, latency 1, active-low hsync
  localparam int HA_B = 2, HFP_B = 1, HS_B = 1, HBP_B = 1;
  localparam int VA_B = 2, VFP_B = 1, VS_B = 1, VBP_B = 1;
  localparam int LAT_B = 1;
  localparam bit HPOL_B = 1'b0, VPOL_B = 1'b1;
  localparam int HT_B = HA_B + HFP_B + HS_B + HBP_B;
  localparam int VT_B = VA_B + VFP_B + VS_B + VBP_B;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  int         mxa, mya, mxb, myb;
  logic [2:0] qa[$];
  logic [2:0] qb[$];

  always #5 clk = ~clk;

  vga_time_gen_if #(.PIX_WIDTH(PW)) ifa ();
  vga_time_gen_if #(.PIX_WIDTH(PW)) ifb ();

  vga_time_gen #(
    .PIX_WIDTH(PW), .H_ACTIVE(HA_A), .H_FP(HFP_A), .H_SYNC(HS_A), .H_BP(HBP_A),
    .V_ACTIVE(VA_A), .V_FP(VFP_A), .V_SYNC(VS_A), .V_BP(VBP_A),
    .H_SYNC_POL(HPOL_A), .V_SYNC_POL(VPOL_A), .DRAW_LATENCY(LAT_A)
  ) dut_a (.clk_i(clk), .rst_i(rst_n), .vga(ifa));

  vga_time_gen #(
    .PIX_WIDTH(PW), .H_ACTIVE(HA_B), .H_FP(HFP_B), .H_SYNC(HS_B), .H_BP(HBP_B),
    .V_ACTIVE(VA_B), .V_FP(VFP_B), .V_SYNC(VS_B), .V_BP(VBP_B),
    .H_SYNC_POL(HPOL_B), .V_SYNC_POL(VPOL_B), .DRAW_LATENCY(LAT_B)
  ) dut_b (.clk_i(clk), .rst_i(rst_n), .vga(ifb));

  // Reference decode of {hs, vs, de} for one counter position.
  function automatic logic [2:0] raw_ref(input int x, input int y,
                                         input int ha, input int hfp, input int hs,
                                         input int va, input int vfp, input int vs,
                                         input bit hp, input bit vp);
    logic h, v, d;
    h = (x >= ha + hfp && x <= ha + hfp + hs - 1) ? hp : !hp;
    v = (y >= va + vfp && y <= va + vfp + vs - 1) ? vp : !vp;
    d = (x < ha) && (y < va);
    return {h, v, d};
  endfunction

  task automatic reset_model();
    mxa = HT_A - 1; mya = VT_A - 1;
    mxb = HT_B - 1; myb = VT_B - 1;
    qa.delete(); qb.delete();
    repeat (LAT_A) qa.push_back({!HPOL_A, !VPOL_A, 1'b0});
    repeat (LAT_B) qb.push_back({!HPOL_B, !VPOL_B, 1'b0});
  endtask

  // One clock: advance the models, push this cycle's decode, pop the one due now.
  task automatic step();
    logic [2:0] ea, eb;
    @(posedge clk); #1;
    if (rst_n) begin
      if (mxa == HT_A - 1) begin mxa = 0; mya = (mya == VT_A - 1) ? 0 : mya + 1; end
      else mxa++;
      if (mxb == HT_B - 1) begin mxb = 0; myb = (myb == VT_B - 1) ? 0 : myb + 1; end
      else mxb++;
      qa.push_back(raw_ref(mxa, mya, HA_A, HFP_A, HS_A, VA_A, VFP_A, VS_A, HPOL_A, VPOL_A));
      qb.push_back(raw_ref(mxb, myb, HA_B, HFP_B, HS_B, VA_B, VFP_B, VS_B, HPOL_B, VPOL_B));
      ea = qa.pop_front();
      eb = qb.pop_front();
      checks += 6;
      if ({ifa.pix_x_o, ifa.pix_y_o} !== {PW'(mxa), PW'(mya)}) begin
        failures++;
        $display("FAIL sb_a_xy: got (%0d,%0d) expected (%0d,%0d)", ifa.pix_x_o, ifa.pix_y_o, mxa, mya);
      end
      if ({ifa.pix_de_o, ifa.frame_start_o} !== {(mxa < HA_A && mya < VA_A), (mxa == 0 && mya == 0)}) begin
        failures++;
        $display("FAIL sb_a_de_fs: got %b%b at (%0d,%0d)", ifa.pix_de_o, ifa.frame_start_o, mxa, mya);
      end
      if ({ifa.vga_hs_o, ifa.vga_vs_o, ifa.vga_de_o} !== ea) begin
        failures++;
        $display("FAIL sb_a_sync: got %b%b%b expected %b at (%0d,%0d)",
                 ifa.vga_hs_o, ifa.vga_vs_o, ifa.vga_de_o, ea, mxa, mya);
      end
      if ({ifb.pix_x_o, ifb.pix_y_o} !== {PW'(mxb), PW'(myb)}) begin
        failures++;
        $display("FAIL sb_b_xy: got (%0d,%0d) expected (%0d,%0d)", ifb.pix_x_o, ifb.pix_y_o, mxb, myb);
      end
      if ({ifb.pix_de_o, ifb.frame_start_o} !== {(mxb < HA_B && myb < VA_B), (mxb == 0 && myb == 0)}) begin
        failures++;
        $display("FAIL sb_b_de_fs: got %b%b at (%0d,%0d)", ifb.pix_de_o, ifb.frame_start_o, mxb, myb);
      end
      if ({ifb.vga_hs_o, ifb.vga_vs_o, ifb.vga_de_o} !== eb) begin
        failures++;
        $display("FAIL sb_b_sync: got %b%b%b expected %b at (%0d,%0d)",
                 ifb.vga_hs_o, ifb.vga_vs_o, ifb.vga_de_o, eb, mxb, myb);
      end
    end
  endtask

  task automatic test_reset();
    logic [28:0] exp_a, exp_b;
    rst_n = 1'b0;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    exp_a = {PW'(HT_A - 1), PW'(VT_A - 1), 1'b0, 1'b0, !HPOL_A, !VPOL_A, 1'b0};
    exp_b = {PW'(HT_B - 1), PW'(VT_B - 1), 1'b0, 1'b0, !HPOL_B, !VPOL_B, 1'b0};
    checks += 2;
    if ({ifa.pix_x_o, ifa.pix_y_o, ifa.pix_de_o, ifa.frame_start_o, ifa.vga_hs_o, ifa.vga_vs_o, ifa.vga_de_o} !== exp_a) begin
      failures++;
      $display("FAIL reset_a: got %h expected %h",
               {ifa.pix_x_o, ifa.pix_y_o, ifa.pix_de_o, ifa.frame_start_o, ifa.vga_hs_o, ifa.vga_vs_o, ifa.vga_de_o}, exp_a);
    end
    if ({ifb.pix_x_o, ifb.pix_y_o, ifb.pix_de_o, ifb.frame_start_o, ifb.vga_hs_o, ifb.vga_vs_o, ifb.vga_de_o} !== exp_b) begin
      failures++;
      $display("FAIL reset_b: got %h expected %h",
               {ifb.pix_x_o, ifb.pix_y_o, ifb.pix_de_o, ifb.frame_start_o, ifb.vga_hs_o, ifb.vga_vs_o, ifb.vga_de_o}, exp_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_frame_timing();
    int   fs0 = -1, fs1 = -1, nfs = 0;
    int   hs_cnt = 0, vs_cnt = 0, vde_cnt = 0, pde_cnt = 0;
    int   hs_rise = -1, vs_rise = -1;
    logic hs_prev = !HPOL_A, vs_prev = !VPOL_A;
    for (int n = 1; n <= FR_A + 1; n++) begin
      step();
      if (ifa.frame_start_o) begin
        nfs++;
        if (fs0 < 0) fs0 = n; else if (fs1 < 0) fs1 = n;
      end
      if (n <= FR_A) begin
        hs_cnt  += int'(ifa.vga_hs_o);
        vs_cnt  += int'(ifa.vga_vs_o);
        vde_cnt += int'(ifa.vga_de_o);
        pde_cnt += int'(ifa.pix_de_o);
        if (ifa.vga_hs_o && !hs_prev && hs_rise < 0) hs_rise = n;
        if (ifa.vga_vs_o && !vs_prev && vs_rise < 0) vs_rise = n;
      end
      hs_prev = ifa.vga_hs_o;
      vs_prev = ifa.vga_vs_o;
    end
    checks += 9;
    if (fs0 != 1) begin failures++; $display("FAIL first_frame_start: cycle %0d expected 1", fs0); end
    if (fs1 - fs0 != FR_A) begin failures++; $display("FAIL frame_period: %0d expected %0d", fs1 - fs0, FR_A); end
    if (nfs != 2) begin failures++; $display("FAIL frame_start_count: %0d expected 2", nfs); end
    if (hs_cnt != HS_A * VT_A) begin failures++; $display("FAIL hs_high_count: %0d expected %0d", hs_cnt, HS_A * VT_A); end
    if (vs_cnt != VS_A * HT_A) begin failures++; $display("FAIL vs_high_count: %0d expected %0d", vs_cnt, VS_A * HT_A); end
    if (vde_cnt != HA_A * VA_A) begin failures++; $display("FAIL vga_de_count: %0d expected %0d", vde_cnt, HA_A * VA_A); end
    if (pde_cnt != HA_A * VA_A) begin failures++; $display("FAIL pix_de_count: %0d expected %0d", pde_cnt, HA_A * VA_A); end
    if (hs_rise != 1 + HA_A + HFP_A + LAT_A) begin
      failures++; $display("FAIL hs_rise_cycle: %0d expected %0d", hs_rise, 1 + HA_A + HFP_A + LAT_A);
    end
    if (vs_rise != 1 + (VA_A + VFP_A) * HT_A + LAT_A) begin
      failures++; $display("FAIL vs_rise_cycle: %0d expected %0d", vs_rise, 1 + (VA_A + VFP_A) * HT_A + LAT_A);
    end
  endtask

  task automatic test_tiny_wrap();
    int   n = 0;
    int   hs_low = 0;
    logic prev_de;
    while (!(mxb == HT_B - 1 && myb == VT_B - 1) && n < 100) begin step(); n++; end
    checks++;
    if (n >= 100) begin failures++; $display("FAIL tiny_corner_wait: not reached in %0d cycles", n); end
    step();
    checks++;
    if ({ifb.pix_x_o, ifb.pix_y_o, ifb.frame_start_o} !== {PW'(0), PW'(0), 1'b1}) begin
      failures++;
      $display("FAIL tiny_corner: got (%0d,%0d) fs=%b expected (0,0) fs=1", ifb.pix_x_o, ifb.pix_y_o, ifb.frame_start_o);
    end
    for (int i = 0; i < HT_B * VT_B; i++) begin
      prev_de = ifb.pix_de_o;
      step();
      hs_low += int'(!ifb.vga_hs_o);
      checks++;
      if (ifb.vga_de_o !== prev_de) begin
        failures++;
        $display("FAIL tiny_de_delay: got %b expected %b at i=%0d", ifb.vga_de_o, prev_de, i);
      end
    end
    checks++;
    if (hs_low != HS_B * VT_B) begin failures++; $display("FAIL tiny_hs_low_count: %0d expected %0d", hs_low, HS_B * VT_B); end
  endtask

  task automatic test_async_reset();
    int          n = 0;
    logic [28:0] exp_a;
    while (!(mxa == 5 && mya == 4) && n < 2 * FR_A) begin step(); n++; end
    checks++;
    if (n >= 2 * FR_A) begin failures++; $display("FAIL async_wait: pixel (5,4) not reached"); end
    #2 rst_n = 1'b0;
    #1;
    reset_model();
    exp_a = {PW'(HT_A - 1), PW'(VT_A - 1), 1'b0, 1'b0, !HPOL_A, !VPOL_A, 1'b0};
    checks += 2;
    if ({ifa.pix_x_o, ifa.pix_y_o, ifa.pix_de_o, ifa.frame_start_o, ifa.vga_hs_o, ifa.vga_vs_o, ifa.vga_de_o} !== exp_a) begin
      failures++;
      $display("FAIL async_reset_a: got %h expected %h",
               {ifa.pix_x_o, ifa.pix_y_o, ifa.pix_de_o, ifa.frame_start_o, ifa.vga_hs_o, ifa.vga_vs_o, ifa.vga_de_o}, exp_a);
    end
    if ({ifb.pix_x_o, ifb.pix_y_o, ifb.vga_hs_o} !== {PW'(HT_B - 1), PW'(VT_B - 1), !HPOL_B}) begin
      failures++;
      $display("FAIL async_reset_b: got (%0d,%0d) hs=%b", ifb.pix_x_o, ifb.pix_y_o, ifb.vga_hs_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if ({ifa.pix_x_o, ifa.pix_y_o, ifa.frame_start_o} !== {PW'(0), PW'(0), 1'b1}) begin
      failures++;
      $display("FAIL restart_origin: got (%0d,%0d) fs=%b expected (0,0) fs=1", ifa.pix_x_o, ifa.pix_y_o, ifa.frame_start_o);
    end
    repeat (FR_A) step();
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      repeat (7 + 11 * r) step();
      @(negedge clk);
      rst_n = 1'b0;
      reset_model();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      checks++;
      if ({ifa.pix_x_o, ifa.pix_y_o, ifa.frame_start_o, ifa.vga_de_o} !== {PW'(0), PW'(0), 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL b2b_restart_%0d: got (%0d,%0d) fs=%b vde=%b", r, ifa.pix_x_o, ifa.pix_y_o,
                 ifa.frame_start_o, ifa.vga_de_o);
      end
    end
    repeat (2 * HT_A) step();
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_tiny_wrap();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
